// File: rtl/pcm_pkg.sv
// Shared PCM definitions: sample width, sample type and the tap-read FSM
// state encoding used by the tap reader and the beamformer tap sequencers.
package pcm_pkg;

    localparam int PCM_W = 19;

    typedef logic signed [PCM_W-1:0] pcm_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HOLD
    } tap_state_t;

endpackage

// File: rtl/pcm_tap_reader_if.sv
// Bus bundle for the PCM tap reader: sample write strobe, tap request
// handshake, tap response handshake and ring fill level.
interface pcm_tap_reader_if
    import pcm_pkg::*;
#(
    parameter int DATA_W = PCM_W,
    parameter int DEPTH  = 32
);
    localparam int AW = $clog2(DEPTH);

    logic                     in_valid;
    logic signed [DATA_W-1:0] in_data;
    logic                     rd_req;
    logic [AW-1:0]            rd_delay;
    logic                     rd_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] out_data;
    logic                     out_err;
    logic                     out_ready;
    logic [AW:0]              fill;

    // Producer / requester / consumer side
    modport master (
        output in_valid, in_data, rd_req, rd_delay, out_ready,
        input  rd_ready, out_valid, out_data, out_err, fill
    );

    // Tap reader side
    modport slave (
        input  in_valid, in_data, rd_req, rd_delay, out_ready,
        output rd_ready, out_valid, out_data, out_err, fill
    );

endinterface

// File: rtl/pcm_ring_ram.sv
// Simple dual-port ring storage: one write port, one registered read port.
// Read-first: a read and a write to the same entry on the same edge returns
// the old contents.
module pcm_ring_ram
    import pcm_pkg::*;
#(
    parameter int DATA_W = PCM_W,
    parameter int DEPTH  = 32
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [$clog2(DEPTH)-1:0]        waddr,
    input  logic signed [DATA_W-1:0]        wdata,
    input  logic                            re,
    input  logic [$clog2(DEPTH)-1:0]        raddr,
    output logic signed [DATA_W-1:0]        rdata
);

    logic signed [DATA_W-1:0] mem [DEPTH];

    // Write and registered read share one edge; nonblocking order gives read-first
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/pcm_tap_reader.sv
// Circular PCM sample store with an addressable tap read port. Samples are
// written into a DEPTH-entry ring; a tap request returns the sample stored
// rd_delay samples before the newest one, or an error flag when that tap
// lies outside the ring or has not been written since reset.
module pcm_tap_reader
    import pcm_pkg::*;
#(
    parameter int DATA_W = PCM_W,
    parameter int DEPTH  = 32
) (
    input  logic clk,
    input  logic rst,
    pcm_tap_reader_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0]            wr_ptr;
    logic [AW:0]              fill_q;
    tap_state_t               state;
    logic                     rd_ready_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_data_q;
    logic                     out_err_q;
    logic                     err_p0;
    logic signed [DATA_W-1:0] ram_q_p1;
    logic                     accept;
    logic [AW-1:0]            rd_addr;

    // Tap address (wr_ptr - 1 - delay) mod DEPTH, wrapped by adding DEPTH so
    // non-power-of-two depths work; out-of-range delays map to entry 0.
    function automatic logic [AW-1:0] tap_addr(input logic [AW-1:0] ptr,
                                               input logic [AW-1:0] dly);
        logic [AW+1:0] base;
        logic [AW+1:0] diff;
        base = {2'b00, ptr} + (AW+2)'(DEPTH - 1);
        diff = '0;
        if ({1'b0, dly} < (AW+1)'(DEPTH)) begin
            diff = base - {2'b00, dly};
            if (diff >= (AW+2)'(DEPTH)) begin
                diff = diff - (AW+2)'(DEPTH);
            end
        end
        return diff[AW-1:0];
    endfunction

    // A tap is invalid beyond the ring size or beyond what has been written
    function automatic logic tap_err(input logic [AW-1:0] dly,
                                     input logic [AW:0]   cnt);
        return ({1'b0, dly} >= (AW+1)'(DEPTH)) || ({1'b0, dly} >= cnt);
    endfunction

    assign accept  = bus.rd_req && rd_ready_q;
    assign rd_addr = tap_addr(wr_ptr, bus.rd_delay);

    assign bus.rd_ready  = rd_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_err   = out_err_q;
    assign bus.fill      = fill_q;

    // Stage p0 -> p1: the RAM read is launched on the accept edge, so the
    // address uses wr_ptr before any same-edge write lands.
    pcm_ring_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (bus.in_valid),
        .waddr (wr_ptr),
        .wdata (bus.in_data),
        .re    (accept),
        .raddr (rd_addr),
        .rdata (ram_q_p1)
    );

    // Write pointer and saturating fill count; writes are never stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            fill_q <= '0;
        end else if (bus.in_valid) begin
            wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (fill_q != (AW+1)'(DEPTH)) begin
                fill_q <= fill_q + 1'b1;
            end
        end
    end

    // Request/response FSM: accept in IDLE, capture RAM data in FETCH, hold in HOLD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_err_q   <= 1'b0;
            err_p0      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        err_p0     <= tap_err(bus.rd_delay, fill_q);
                        rd_ready_q <= 1'b0;
                        state      <= FETCH;
                    end
                end
                // Stage p1 -> p2: registered RAM data becomes the response
                FETCH: begin
                    out_data_q  <= err_p0 ? '0 : ram_q_p1;
                    out_err_q   <= err_p0;
                    out_valid_q <= 1'b1;
                    state       <= HOLD;
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        rd_ready_q  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    rd_ready_q  <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pcm_tap_reader.sv
// Bench for pcm_tap_reader: a DEPTH=32 and a DEPTH=24 instance, constant
// vector tables, hand sequences for stall/reset/same-cycle cases and a
// randomized phase scored against a sample-history model.
module tb_pcm_tap_reader;
    import pcm_pkg::*;

    localparam int D0 = 32;
    localparam int D1 = 24;
    localparam int HMAX = 8192;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pcm_tap_reader_if #(.DATA_W(PCM_W), .DEPTH(D0)) bus0 ();
    pcm_tap_reader_if #(.DATA_W(PCM_W), .DEPTH(D1)) bus1 ();

    pcm_tap_reader #(.DATA_W(PCM_W), .DEPTH(D0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    pcm_tap_reader #(.DATA_W(PCM_W), .DEPTH(D1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    logic        in_valid  [2];
    logic [18:0] in_data   [2];
    logic        rd_req    [2];
    logic [4:0]  rd_delay  [2];
    logic        out_ready [2];
    logic        rdy [2];
    logic        ov  [2];
    logic [18:0] od  [2];
    logic        oe  [2];
    logic [5:0]  fl  [2];

    assign bus0.in_valid  = in_valid[0];
    assign bus0.in_data   = in_data[0];
    assign bus0.rd_req    = rd_req[0];
    assign bus0.rd_delay  = rd_delay[0];
    assign bus0.out_ready = out_ready[0];
    assign bus1.in_valid  = in_valid[1];
    assign bus1.in_data   = in_data[1];
    assign bus1.rd_req    = rd_req[1];
    assign bus1.rd_delay  = rd_delay[1];
    assign bus1.out_ready = out_ready[1];

    assign rdy[0] = bus0.rd_ready;
    assign ov[0]  = bus0.out_valid;
    assign od[0]  = bus0.out_data;
    assign oe[0]  = bus0.out_err;
    assign fl[0]  = bus0.fill;
    assign rdy[1] = bus1.rd_ready;
    assign ov[1]  = bus1.out_valid;
    assign od[1]  = bus1.out_data;
    assign oe[1]  = bus1.out_err;
    assign fl[1]  = bus1.fill;

    int checks   = 0;
    int failures = 0;

    // Reference model: full history of samples written since reset
    logic [18:0] hist [2][HMAX];
    int          wc   [2];

    typedef struct {
        int          dly;
        logic [18:0] ed;
        bit          ee;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int depth_of(input int s);
        return (s == 0) ? D0 : D1;
    endfunction

    function automatic int model_fill(input int s);
        return (wc[s] < depth_of(s)) ? wc[s] : depth_of(s);
    endfunction

    task automatic model_w(input int s, input logic [18:0] v);
        if (wc[s] < HMAX) begin
            hist[s][wc[s]] = v;
            wc[s]++;
        end
    endtask

    task automatic model_exp(input int s, input int dly, output logic [18:0] d, output bit e);
        e = (dly >= depth_of(s)) || (dly >= model_fill(s));
        d = e ? 19'd0 : hist[s][wc[s] - 1 - dly];
    endtask

    // Called at a falling edge; leaves the bench at a falling edge
    task automatic wr_seq(input int s, input int n, input int start);
        for (int i = 0; i < n; i++) begin
            in_valid[s] = 1'b1;
            in_data[s]  = 19'(start + i);
            model_w(s, 19'(start + i));
            @(negedge clk);
        end
        in_valid[s] = 1'b0;
    endtask

    // Full request/response transaction, optional same-cycle write at accept,
    // optional stall cycles in HOLD with writes running underneath
    task automatic do_read(input int s, input int dly, input logic [18:0] ed, input bit ee,
                           input bit wr, input logic [18:0] wd, input int stall);
        logic [18:0] v;
        in_valid[s] = wr;
        in_data[s]  = wd;
        if (wr) model_w(s, wd);
        rd_req[s]   = 1'b1;
        rd_delay[s] = 5'(dly);
        chk("rd_ready_idle", 32'(rdy[s]), 32'd1);
        @(negedge clk);
        in_valid[s] = 1'b0;
        rd_req[s]   = 1'b0;
        chk("fetch_no_valid", 32'(ov[s]), 32'd0);
        chk("fetch_rd_ready", 32'(rdy[s]), 32'd0);
        @(negedge clk);
        chk("latency_valid", 32'(ov[s]), 32'd1);
        chk("out_data", 32'(od[s]), 32'(ed));
        chk("out_err", 32'(oe[s]), 32'(ee));
        for (int i = 0; i < stall; i++) begin
            v = 19'($urandom);
            in_valid[s] = 1'b1;
            in_data[s]  = v;
            model_w(s, v);
            @(negedge clk);
            chk("hold_valid", 32'(ov[s]), 32'd1);
            chk("hold_data", 32'(od[s]), 32'(ed));
            chk("hold_rd_ready", 32'(rdy[s]), 32'd0);
            chk("hold_fill", 32'(fl[s]), 32'(model_fill(s)));
        end
        in_valid[s]  = 1'b0;
        out_ready[s] = 1'b1;
        @(negedge clk);
        out_ready[s] = 1'b0;
        chk("release_valid", 32'(ov[s]), 32'd0);
        chk("release_rd_ready", 32'(rdy[s]), 32'd1);
    endtask

    task automatic model_read(input int s, input int dly, input bit wr, input int stall);
        logic [18:0] ed;
        bit          ee;
        model_exp(s, dly, ed, ee);
        do_read(s, dly, ed, ee, wr, 19'($urandom), stall);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        wc[0] = 0;
        wc[1] = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            in_valid[s]  = 1'b0;
            in_data[s]   = '0;
            rd_req[s]    = 1'b0;
            rd_delay[s]  = '0;
            out_ready[s] = 1'b0;
        end
        rst = 1'b1;
        apply_reset();

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            chk("reset_rd_ready", 32'(rdy[s]), 32'd1);
            chk("reset_out_valid", 32'(ov[s]), 32'd0);
            chk("reset_out_data", 32'(od[s]), 32'd0);
            chk("reset_out_err", 32'(oe[s]), 32'd0);
            chk("reset_fill", 32'(fl[s]), 32'd0);
        end

        // Five samples, constant expectation table
        tbl[0] = '{dly: 0,  ed: 19'd5, ee: 1'b0};
        tbl[1] = '{dly: 4,  ed: 19'd1, ee: 1'b0};
        tbl[2] = '{dly: 2,  ed: 19'd3, ee: 1'b0};
        tbl[3] = '{dly: 5,  ed: 19'd0, ee: 1'b1};
        tbl[4] = '{dly: 31, ed: 19'd0, ee: 1'b1};
        tbl[5] = '{dly: 1,  ed: 19'd4, ee: 1'b0};
        wr_seq(0, 5, 1);
        chk("fill_after_5", 32'(fl[0]), 32'd5);
        for (int i = 0; i < 6; i++) begin
            do_read(0, tbl[i].dly, tbl[i].ed, tbl[i].ee, 1'b0, 19'd0, 0);
        end

        // 40 samples into DEPTH=32: saturation and wrap
        apply_reset();
        wr_seq(0, 40, 1);
        chk("fill_sat_32", 32'(fl[0]), 32'd32);
        do_read(0, 0, 19'd40, 1'b0, 1'b0, 19'd0, 0);
        do_read(0, 31, 19'd9, 1'b0, 1'b0, 19'd0, 0);
        do_read(0, 16, 19'd24, 1'b0, 1'b0, 19'd0, 0);

        // 30 samples into DEPTH=24: non-power-of-two wrap and range
        wr_seq(1, 30, 1);
        chk("fill_sat_24", 32'(fl[1]), 32'd24);
        do_read(1, 23, 19'd7, 1'b0, 1'b0, 19'd0, 0);
        do_read(1, 24, 19'd0, 1'b1, 1'b0, 19'd0, 0);
        do_read(1, 31, 19'd0, 1'b1, 1'b0, 19'd0, 0);
        do_read(1, 0, 19'd30, 1'b0, 1'b0, 19'd0, 0);

        // Consumer stalls 10 cycles while writes continue; then new samples visible
        do_read(0, 0, 19'd40, 1'b0, 1'b0, 19'd0, 10);
        model_read(0, 0, 1'b0, 0);
        model_read(0, 10, 1'b0, 0);

        // Asynchronous reset while a response is held
        rd_req[0]   = 1'b1;
        rd_delay[0] = 5'd1;
        @(negedge clk);
        rd_req[0] = 1'b0;
        @(negedge clk);
        chk("pre_reset_valid", 32'(ov[0]), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_valid", 32'(ov[0]), 32'd0);
        chk("async_reset_fill", 32'(fl[0]), 32'd0);
        chk("async_reset_rd_ready", 32'(rdy[0]), 32'd1);
        wc[0] = 0;
        wc[1] = 0;
        @(negedge clk);
        rst = 1'b0;

        // Request at delay 0 with a write on the same edge sees the prior newest
        wr_seq(0, 2, 7);
        do_read(0, 0, 19'd8, 1'b0, 1'b1, 19'd9, 0);
        do_read(0, 0, 19'd9, 1'b0, 1'b0, 19'd0, 0);
        do_read(0, 3, 19'd0, 1'b1, 1'b0, 19'd0, 0);

        // Randomized traffic on both instances against the history model
        for (int it = 0; it < 300; it++) begin
            int s;
            s = int'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) begin
                wr_seq(s, int'($urandom_range(1, 4)), int'($urandom));
            end else begin
                model_read(s, int'($urandom_range(0, 31)),
                           ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
            end
            chk("rand_fill", 32'(fl[s]), 32'(model_fill(s)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pcm_tap_reader.md
Name: pcm_tap_reader

Overview:
- Circular PCM sample store with an addressable read port.
- Write side takes one 19-bit PCM sample per in_valid strobe into a DEPTH-entry ring.
- Read side accepts a delay request (in samples) through a valid/ready handshake and returns the stored sample that many samples in the past.
- Sits between the mic PCM decimator output and the beamformer's per-channel steering logic, which fetches arbitrary taps per steering angle.

Parameters:
- DATA_W, 19, PCM sample width.
- DEPTH, 32, ring entries (>=2; need not be a power of two).
- AW, $clog2(DEPTH), pointer and delay width (derived, not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  write strobe, one sample per cycle max
- in_data  in  DATA_W  PCM sample to store
- rd_req  in  1  read request valid
- rd_delay  in  AW  tap delay in samples; 0 = newest stored sample
- rd_ready  out  1  request accepted when rd_req && rd_ready
- out_valid  out  1  response valid
- out_data  out  DATA_W  returned sample
- out_err  out  1  response flag: delay out of range or not yet filled; out_data forced 0
- out_ready  in  1  consumer accepts response
- fill  out  AW+1  stored sample count, saturating at DEPTH

Behaviour:
- Reset values: wr_ptr=0, fill=0, state=IDLE, rd_ready=1, out_valid=0, out_data=0, out_err=0. Ring contents are not cleared; reads are gated by fill.
- Write path:
  - On in_valid: mem[wr_ptr]<=in_data.
  - wr_ptr<=(wr_ptr==DEPTH-1)?0:wr_ptr+1.
  - fill<=min(fill+1,DEPTH).
  - Writes are independent of read state and are never stalled.
- Read address: (wr_ptr-1-rd_delay) mod DEPTH. Compute it with explicit wrap using an add of DEPTH, not a power-of-two mask.
- Snapshot rule: the address and range check use wr_ptr and fill as registered at the accept cycle. A write in the same cycle is not visible, so delay 0 returns the previously newest sample.
- Range check at accept: err = (rd_delay >= DEPTH) || (rd_delay >= fill).
- FSM:
  - IDLE: rd_ready=1. On rd_req, latch address and err, go to FETCH.
  - FETCH: rd_ready=0. Synchronous RAM read issued. Go to HOLD and load out_data (0 if err) and out_err.
  - HOLD: out_valid=1. out_data and out_err are held stable until out_ready. On out_ready, go to IDLE and clear out_valid.
- Latency: accept at cycle N gives out_valid at N+2. Back-to-back throughput is one request per 3 cycles with out_ready held high.
- Overwrite hazard: if the ring wraps onto the latched address during FETCH, the read returns the pre-write value. RAM is read-first.
- Reset mid-operation: any state returns to IDLE immediately. The pending response is dropped and out_valid deasserts asynchronously.
- rd_req while rd_ready=0 is ignored; the requester must hold it.

Decomposition:
- Shared package pcm_pkg holds:
  - PCM_W=19
  - the sample typedef pcm_t
  - the FSM enum {IDLE,FETCH,HOLD}, reused by the beamformer tap sequencers.
- One sub-module: pcm_ring_ram, a simple dual-port read-first RAM (DEPTH x DATA_W, registered read). The FSM and pointer logic stay in the top.

Test Plan:
- Reset, write 1..5 (in_valid pulses), request delay 0 -> out_valid 2 cycles after accept, out_data=5, out_err=0; delay 4 -> 1; fill=5.
- After 5 writes, request delay 5 -> out_err=1, out_data=0; rd_delay=31 with fill=32 -> valid, no error.
- Write 40 samples (values 1..40) with DEPTH=32 -> fill saturates at 32; delay 0 -> 40, delay 31 -> 9 (wrap-around correct).
- DEPTH=24 build: write 30 samples, delay 23 -> 7; rd_delay=24 or 31 -> out_err=1 (non-power-of-two wrap and range).
- Hold out_ready=0 for 10 cycles -> out_valid and out_data stable, rd_ready=0, writes continue and fill increments. Release -> IDLE, and the next request sees the new samples.
- Assert rst during HOLD -> out_valid=0 immediately, fill=0, rd_ready=1. Same-cycle write plus request at delay 0 -> returns the prior newest sample, not in_data.
